// File: rtl/openhw_mdu_seq.sv
// openhw_mdu_seq: sequential RISC-V M-extension multiply/divide unit.
// Multiplies complete in one working cycle. Divides use restoring division
// that retires DIV_BITS quotient bits per cycle.
//
// Parameters: XLEN (32|64) datapath width, DIV_BITS (1|2|4) quotient bits per
// divide iteration.
// Ports:
//   clk, reset (sync, active-low), flush (abort in-flight op)
//   req_valid/req_ready, funct3, w64, src_a, src_b : request side
//   resp_valid/resp_ready, result                   : response side
//   busy : high whenever the unit is not idle
// Optional feature: define OPENHW_MDU_SEQ_REMCACHE_EN to keep the operands and
// results of the last completed iterative divide. A matching div/rem request
// then completes without iterating.
module openhw_mdu_seq #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned DIV_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic            w64,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned   NMAX   = XLEN / DIV_BITS;
  localparam int unsigned   CW     = $clog2(NMAX) + 1;
  localparam logic [CW-1:0] N_FULL = CW'(NMAX);
  localparam logic [CW-1:0] N_W    = CW'(32 / DIV_BITS);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, DPREP, DITER, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // W-type results are always sign-extended from bit 31
  function automatic logic [XLEN-1:0] fin(input logic wf, input logic [XLEN-1:0] v);
    return wf ? sx32(v[31:0]) : v;
  endfunction

  logic [2:0]      op;
  logic            w;
  logic [XLEN-1:0] a, b;
  logic [XLEN-1:0] dq, rem, dvs;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r;
  logic            w_in;
  logic            cache_hit;
  logic [XLEN-1:0] hit_val;

  assign w_in      = (XLEN == 64) && w64;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Divide operand preparation
  logic            div_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] ea, eb, ma, mb, q_spec, r_spec;
  always_comb begin
    div_signed = ~op[0];
    ea = w ? (div_signed ? sx32(a[31:0]) : XLEN'(a[31:0])) : a;
    eb = w ? (div_signed ? sx32(b[31:0]) : XLEN'(b[31:0])) : b;
    sa = div_signed & ea[XLEN-1];
    sb = div_signed & eb[XLEN-1];
    ma = sa ? -ea : ea;
    mb = sb ? -eb : eb;
    div_zero = (eb == '0);
    div_ovf  = div_signed && (ea == (w ? sx32(32'h8000_0000) : MIN_X)) && (eb == '1);
    q_spec   = div_zero ? '1 : ea;
    r_spec   = div_zero ? ea : '0;
  end

  // Multiply
  logic            mul_sa, mul_sb;
  logic [2*XLEN-1:0] pa, pb, prod;
  logic [XLEN-1:0] mul_res;
  always_comb begin
    mul_sa  = ((op == 3'b001) || (op == 3'b010)) && a[XLEN-1];
    mul_sb  = (op == 3'b001) && b[XLEN-1];
    pa      = {{XLEN{mul_sa}}, a};
    pb      = {{XLEN{mul_sb}}, b};
    prod    = pa * pb;
    mul_res = (w || (op[1:0] == 2'b00)) ? fin(w, prod[XLEN-1:0]) : prod[2*XLEN-1:XLEN];
  end

  // DIV_BITS restoring steps per cycle; dq shifts dividend bits out at the top
  // and quotient bits in at the bottom.
  logic [XLEN:0]   it_rem;
  logic [XLEN-1:0] it_dq, q_s, r_s;
  always_comb begin
    it_rem = {1'b0, rem};
    it_dq  = dq;
    for (int unsigned i = 0; i < DIV_BITS; i++) begin
      it_rem = {it_rem[XLEN-1:0], it_dq[XLEN-1]};
      it_dq  = {it_dq[XLEN-2:0], 1'b0};
      if (it_rem >= {1'b0, dvs}) begin
        it_rem   = it_rem - {1'b0, dvs};
        it_dq[0] = 1'b1;
      end
    end
    q_s = neg_q ? -it_dq : it_dq;
    r_s = neg_r ? -it_rem[XLEN-1:0] : it_rem[XLEN-1:0];
  end

`ifdef OPENHW_MDU_SEQ_REMCACHE_EN
  logic            c_valid, c_sgn, c_w;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r;
  assign cache_hit = c_valid && funct3[2] && (src_a == c_a) && (src_b == c_b) &&
                     (c_sgn == ~funct3[0]) && (c_w == w_in);
  assign hit_val   = funct3[1] ? c_r : c_q;
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      c_valid <= 1'b0;
      c_sgn   <= 1'b0;
      c_w     <= 1'b0;
      c_a     <= '0;
      c_b     <= '0;
      c_q     <= '0;
      c_r     <= '0;
    end else if ((state == DITER) && (cnt == CW'(1))) begin
      c_valid <= 1'b1;
      c_sgn   <= div_signed;
      c_w     <= w;
      c_a     <= a;
      c_b     <= b;
      c_q     <= q_s;
      c_r     <= r_s;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_val   = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = cache_hit ? DONE : (funct3[2] ? DPREP : MUL);
      MUL:     state_nxt = DONE;
      DPREP:   state_nxt = (div_zero || div_ovf) ? DONE : DITER;
      DITER:   if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (resp_valid && resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // resp_valid is registered from DONE, so it rises one cycle after DONE entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      op         <= '0;
      w          <= 1'b0;
      a          <= '0;
      b          <= '0;
      dq         <= '0;
      rem        <= '0;
      dvs        <= '0;
      cnt        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      result     <= '0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= (state == DONE) && !flush && !(resp_valid && resp_ready);
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: if (req_valid) begin
            op <= funct3;
            w  <= w_in;
            a  <= src_a;
            b  <= src_b;
            if (cache_hit) result <= fin(w_in, hit_val);
          end
          MUL: result <= mul_res;
          DPREP: begin
            dq    <= w ? (ma << (XLEN - 32)) : ma;
            rem   <= '0;
            dvs   <= mb;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            if (div_zero || div_ovf) begin
              cnt    <= '0;
              result <= fin(w, op[1] ? r_spec : q_spec);
            end else begin
              cnt <= w ? N_W : N_FULL;
            end
          end
          DITER: begin
            dq  <= it_dq;
            rem <= it_rem[XLEN-1:0];
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) result <= fin(w, op[1] ? r_s : q_s);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_openhw_mdu_seq.sv
module tb_openhw_mdu_seq;
  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, w64, resp_valid, resp_ready, busy;
  logic [2:0]  funct3;
  logic [63:0] src_a, src_b, result;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  openhw_mdu_seq #(.XLEN(64), .DIV_BITS(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .w64(w64), .src_a(src_a), .src_b(src_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .busy(busy)
  );

`ifdef OPENHW_MDU_SEQ_REMCACHE_EN
  bit          mc_valid = 0;
  bit          mc_s, mc_w;
  logic [63:0] mc_a, mc_b;
`endif

  task automatic invalidate();
`ifdef OPENHW_MDU_SEQ_REMCACHE_EN
    mc_valid = 0;
`endif
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: RISC-V M semantics with plain wide arithmetic
  function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    logic [63:0] q, r;
    longint sa64, sb64;
    int sa32, sb32;
    int unsigned ua32, ub32;
    if (!f[2]) begin
      if (w || f == 3'b000) begin
        p = a * b;
        return w ? sx32(p[31:0]) : p[63:0];
      end
      case (f)
        3'b001:  begin pa = $signed(a); pb = $signed(b); end
        3'b010:  begin pa = $signed(a); pb = b; end
        default: begin pa = a; pb = b; end
      endcase
      p = pa * pb;
      return p[127:64];
    end
    if (w) begin
      sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      if (!f[0]) begin
        if (sb32 == 0) begin q = '1; r = sx32(sa32); end
        else if (sa32 == 32'sh8000_0000 && sb32 == -1) begin q = sx32(sa32); r = 0; end
        else begin q = sx32(sa32 / sb32); r = sx32(sa32 % sb32); end
      end else begin
        if (ub32 == 0) begin q = '1; r = sx32(ua32); end
        else begin q = sx32(ua32 / ub32); r = sx32(ua32 % ub32); end
      end
    end else begin
      sa64 = a; sb64 = b;
      if (!f[0]) begin
        if (sb64 == 0) begin q = '1; r = a; end
        else if (a == 64'h8000_0000_0000_0000 && sb64 == -1) begin q = a; r = 0; end
        else begin q = sa64 / sb64; r = sa64 % sb64; end
      end else begin
        if (b == 0) begin q = '1; r = a; end
        else begin q = a / b; r = a % b; end
      end
    end
    return f[1] ? r : q;
  endfunction

  // Expected accept-to-resp_valid latency; tracks the retained-divide state
  function automatic int exp_lat(input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    bit spec;
    if (!f[2]) return 2;
    if (w) spec = (b[31:0] == 0) || (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else   spec = (b == 0) || (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    if (spec) return 2;
`ifdef OPENHW_MDU_SEQ_REMCACHE_EN
    if (mc_valid && mc_a == a && mc_b == b && mc_s == !f[0] && mc_w == w) return 1;
    mc_valid = 1; mc_a = a; mc_b = b; mc_s = !f[0]; mc_w = w;
`endif
    return 2 + (w ? 32 : 64) / 2;
  endfunction

  task automatic start(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
    chk("req_ready", 64'(req_ready), 64'd1);
    req_valid = 1; funct3 = f; w64 = w; src_a = a; src_b = b;
    @(posedge clk); #1;
    req_valid = 0; funct3 = 3'($urandom); w64 = 1'($urandom);
    src_a = {$urandom, $urandom}; src_b = {$urandom, $urandom};
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!resp_valid && lat < 200);
  endtask

  task automatic issue(input string tag, input logic [2:0] f, input logic w,
                       input logic [63:0] a, input logic [63:0] b, output logic [63:0] got);
    int lat, elat;
    logic [63:0] exp;
    exp  = model(f, w, a, b);
    elat = exp_lat(f, w, a, b);
    start(f, w, a, b);
    wait_resp(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_res"}, result, exp);
    got = result;
    @(posedge clk); #1;
    chk({tag, "_idle"}, {62'b0, resp_valid, busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] got, exp, a, b;
    logic [2:0]  f;
    logic        w;
    int          lat, seen;

    reset = 0; flush = 0; req_valid = 1; resp_ready = 1;
    funct3 = 3'b100; w64 = 0; src_a = 64'd9; src_b = 64'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {62'b0, resp_valid, busy}, 64'd0);
    chk("rst_result", result, 64'd0);
    req_valid = 0; reset = 1;
    chk("rst_ready", 64'(req_ready), 64'd1);

    issue("div_100_7", 3'b100, 0, 64'd100, 64'd7, got);
    chk("div_100_7_val", got, 64'd14);
    issue("rem_m100_7", 3'b110, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, got);
    chk("rem_m100_7_val", got, 64'hFFFF_FFFF_FFFF_FFFE);
    issue("divu_by0", 3'b101, 0, 64'd5, 64'd0, got);
    chk("divu_by0_val", got, 64'hFFFF_FFFF_FFFF_FFFF);
    issue("div_ovf", 3'b100, 0, 64'h8000_0000_0000_0000, '1, got);
    chk("div_ovf_val", got, 64'h8000_0000_0000_0000);
    issue("mulh", 3'b001, 0, '1, 64'd2, got);
    chk("mulh_val", got, 64'hFFFF_FFFF_FFFF_FFFF);
    issue("mulhu", 3'b011, 0, '1, 64'd2, got);
    chk("mulhu_val", got, 64'd1);
    issue("divw", 3'b100, 1, 64'h0000_0001_8000_0000, 64'd1, got);
    chk("divw_val", got, 64'hFFFF_FFFF_8000_0000);

    // repeated divide operands, then with a flush in between
    issue("rc_div", 3'b100, 0, 64'd100, 64'd7, got);
    issue("rc_rem", 3'b110, 0, 64'd100, 64'd7, got);
    chk("rc_rem_val", got, 64'd2);
    flush = 1; @(posedge clk); #1; flush = 0; invalidate();
    issue("rc_rem_flushed", 3'b110, 0, 64'd100, 64'd7, got);

    // backpressure: result must hold while resp_ready is low
    resp_ready = 0;
    exp = model(3'b000, 0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    start(3'b000, 0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    wait_resp(lat);
    chk("bp_lat", 64'(lat), 64'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_hold", result, exp);
    end
    resp_ready = 1;
    @(posedge clk); #1;
    chk("bp_release", {62'b0, resp_valid, busy}, 64'd0);

    // flush in the third divide iteration
    start(3'b101, 0, 64'd123456789, 64'd1000);
    repeat (3) begin @(posedge clk); #1; end
    chk("fl_busy", 64'(busy), 64'd1);
    flush = 1; @(posedge clk); #1; flush = 0; invalidate();
    chk("fl_idle", {61'b0, req_ready, resp_valid, busy}, 64'd4);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid) seen++; end
    chk("fl_no_resp", 64'(seen), 64'd0);

    // flush beats a simultaneous accept
    req_valid = 1; flush = 1; funct3 = 3'b000; src_a = 64'd3; src_b = 64'd4;
    @(posedge clk); #1; req_valid = 0; flush = 0; invalidate();
    chk("fl_accept", {62'b0, busy, req_ready}, 64'd1);

    // flush beats resp_ready in DONE
    start(3'b000, 0, 64'd6, 64'd7);
    wait_resp(lat);
    flush = 1; @(posedge clk); #1; flush = 0; invalidate();
    chk("fl_done", {62'b0, resp_valid, busy}, 64'd0);

    // reset in the middle of a divide
    start(3'b100, 0, 64'd999999, 64'd13);
    repeat (5) begin @(posedge clk); #1; end
    reset = 0; @(posedge clk); #1;
    chk("mid_rst", {62'b0, resp_valid, busy}, 64'd0);
    chk("mid_rst_result", result, 64'd0);
    reset = 1; invalidate();
    issue("post_rst", 3'b100, 0, 64'd999999, 64'd13, got);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      w = ($urandom_range(0, 3) == 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: b = 64'($urandom_range(1, 20));
        3: a = 64'h8000_0000_0000_0000;
        4: a = {$urandom, 32'h8000_0000};
        5: begin a = 64'($urandom_range(0, 1000)); b = -64'($urandom_range(1, 9)); end
        default: ;
      endcase
      issue("rnd", f, w, a, b, got);
      if (i % 8 == 3) issue("rnd_rpt", f ^ 3'b010, w, a, b, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
